// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative AES-128 encryption controller. It owns the 128-bit state
// register, the round-key register, the round counter and the Rcon
// generator. It steps an external combinational round datapath and an
// external key-expansion step, one round per clock.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. The producer holds valid and data stable until that
// edge. ready never depends combinationally on valid.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      plaintext/key offered
//   in_ready      block accepted on in_valid & in_ready (IDLE only)
//   pt, key       plaintext and cipher key, sampled on acceptance
//   rnd_state     state register, drives the external round datapath
//   rk_cur        round key r-1, drives the external key expansion
//   rcon          Rcon byte for the round being computed (00 outside ROUND)
//   final_round   round == NR; the external datapath skips MixColumns
//   rk_next       round key r from the external key expansion
//   rnd_result    external round output
//   out_valid     ciphertext valid (DONE)
//   out_ready     consumer accepts the ciphertext
//   ct            ciphertext, equal to the state register
//   busy          high in ROUND or DONE
//
// All 128-bit buses use [0:127] ordering, so byte 0 is bits [0:7]
// (column-major, as in FIPS-197).
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int NR = 10  // legal range 2..10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] pt,
  input  logic [0:127] key,
  output logic [0:127] rnd_state,
  output logic [0:127] rk_cur,
  output logic [7:0]   rcon,
  output logic         final_round,
  input  logic [0:127] rk_next,
  input  logic [0:127] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ct,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state;
  logic [0:127] state_reg;
  logic [0:127] rk_reg;
  logic [3:0]   round;

  // Rcon(r) for rounds 1..10. Other indices return 00.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign rnd_state = state_reg;
  assign rk_cur    = rk_reg;
  assign ct        = state_reg;

  // Every control output is registered. Each one is loaded together with
  // the state transition that changes it, so it is valid in the same cycle
  // as the new state. No path runs from any input to in_ready, out_valid
  // or busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      state_reg   <= '0;
      rk_reg      <= '0;
      round       <= 4'd0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      final_round <= 1'b0;
      rcon        <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          // in_ready comes up on the first edge after reset release.
          // Afterwards it stays high until a block is accepted.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state_reg   <= pt ^ key;   // initial AddRoundKey
            rk_reg      <= key;
            round       <= 4'd1;
            state       <= ROUND;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            rcon        <= rcon_of(4'd1);
            final_round <= (NR_L == 4'd1);
          end
        end

        ROUND: begin
          state_reg <= rnd_result;
          rk_reg    <= rk_next;
          if (round == NR_L) begin
            state       <= DONE;
            round       <= 4'd0;
            rcon        <= 8'h00;
            final_round <= 1'b0;
            out_valid   <= 1'b1;
          end else begin
            round       <= round + 4'd1;
            rcon        <= rcon_of(round + 4'd1);
            final_round <= ((round + 4'd1) == NR_L);
          end
        end

        DONE: begin
          // Leaving DONE raises in_ready one cycle later, so a block is
          // never reloaded in the same cycle the ciphertext is taken.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Testbench for aes_round_sequencer with NR = 10. It supplies the external
// AES round datapath and the key-expansion step as combinational functions.
// Ciphertexts are checked against published AES-128 vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] pt;
  logic [0:127] key;
  logic [0:127] rnd_state;
  logic [0:127] rk_cur;
  logic [7:0]   rcon;
  logic         final_round;
  logic [0:127] rk_next;
  logic [0:127] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] ct;
  logic         busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_sequencer #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pt         (pt),
    .key        (key),
    .rnd_state  (rnd_state),
    .rk_cur     (rk_cur),
    .rcon       (rcon),
    .final_round(final_round),
    .rk_next    (rk_next),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ct         (ct),
    .busy       (busy)
  );

  // ---------------- external AES datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    logic [7:0] s;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    s = inv ^ 8'h63;
    for (int k = 1; k <= 4; k++) begin
      logic [7:0] r;
      r = (inv << k) | (inv >> (8 - k));
      s = s ^ r;
    end
    return s;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s,
                                             input logic [0:127] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [0:127] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c + r] = b[4*((c + r) % 4) + r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ k[8*i +: 8];
    return o;
  endfunction

  function automatic logic [0:127] key_step(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, tmp;
    w0 = k[0 +: 32]; w1 = k[32 +: 32]; w2 = k[64 +: 32]; w3 = k[96 +: 32];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    tmp = tmp ^ {rc, 24'h000000};
    w0 = w0 ^ tmp;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    rk_next    = key_step(rk_cur, rcon);
    rnd_result = aes_round(rnd_state, rk_next, final_round);
  end

  // ---------------- scoreboard / checks ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string        name;
    logic [0:127] key;
    logic [0:127] pt;
    logic [0:127] ct;
  } vec_t;

  vec_t vecs [3];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one block through acceptance, all rounds, an optional out_ready
  // hold-off and the output handshake, checking the trace on every cycle.
  task automatic run_block(input vec_t v, input int hold, input bit disturb);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk({v.name, "_in_ready_idle"}, in_ready, 1);
    pt = v.pt; key = v.key; in_valid = 1'b1;
    step();                                   // acceptance edge E0
    in_valid = 1'b0;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk({v.name, "_ark_state"}, rnd_state, v.pt ^ v.key);
    chk({v.name, "_busy"}, busy, 1);
    chk({v.name, "_in_ready_busy"}, in_ready, 0);
    for (int r = 1; r <= 10; r++) begin
      chk($sformatf("%s_rcon_r%0d", v.name, r), rcon, rcon_tab[r-1]);
      chk($sformatf("%s_final_r%0d", v.name, r), final_round, (r == 10));
      chk($sformatf("%s_out_valid_r%0d", v.name, r), out_valid, 0);
      if (disturb && r == 3) out_ready = 1'b1;
      if (disturb && r == 5) begin
        in_valid = 1'b1;
        pt = 128'h00112233445566778899aabbccddeeff;
        key = 128'h000102030405060708090a0b0c0d0e0f;
      end
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
    end
    chk({v.name, "_out_valid"}, out_valid, 1);
    chk({v.name, "_ct"}, ct, v.ct);
    chk({v.name, "_busy_done"}, busy, 1);
    for (int h = 0; h < hold; h++) begin
      step();
      chk($sformatf("%s_hold_valid_%0d", v.name, h), out_valid, 1);
      chk($sformatf("%s_hold_ct_%0d", v.name, h), ct, v.ct);
      chk($sformatf("%s_hold_in_ready_%0d", v.name, h), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, "_out_valid_after"}, out_valid, 0);
    chk({v.name, "_in_ready_after"}, in_ready, 1);
    chk({v.name, "_busy_after"}, busy, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int acc_cyc [2];
    logic [0:127] ct_got [2];
    int n_acc, n_ct;

    vecs[0] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"zeros", 128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_final_round", final_round, 0);
    chk("rst_rcon", rcon, 0);
    chk("rst_state", rnd_state, 0);
    chk("rst_rk", rk_cur, 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", in_ready, 1);

    // Table-driven known-answer vectors.
    for (int i = 0; i < 3; i++) run_block(vecs[i], 0, 1'b0);

    // Backpressure plus ignored in_valid / stray out_ready while busy.
    run_block(vecs[0], 20, 1'b1);

    // Asynchronous reset between edges in round 4.
    pt = vecs[1].pt; key = vecs[1].key; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_state", rnd_state, 0);
    #2 rst = 1'b0;
    step();
    chk("arst_release_in_ready", in_ready, 1);
    chk("arst_release_out_valid", out_valid, 0);
    run_block(vecs[0], 0, 1'b0);

    // Back-to-back blocks with in_valid held high and out_ready high.
    n_acc = 0; n_ct = 0;
    pt = vecs[0].pt; key = vecs[0].key; in_valid = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < 60 && n_ct < 2; s++) begin
      bit acc;
      acc = in_ready && in_valid;
      if (acc && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; end
      if (out_valid) begin ct_got[n_ct] = ct; n_ct++; end
      step();
      if (acc && n_acc == 1) begin pt = vecs[1].pt; key = vecs[1].key; end
      if (acc && n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_outputs", n_ct, 2);
    if (n_acc == 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 12);
    if (n_ct == 2) begin
      chk("b2b_ct0", ct_got[0], vecs[0].ct);
      chk("b2b_ct1", ct_got[1], vecs[1].ct);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller that sequences one external combinational round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) and one external key-expansion step, one round per clock.
- Owns the 128-bit state register, the round-key register, the round counter, the Rcon generator and the valid/ready handshakes.
- Sits between the block-input interface and the ciphertext consumer.
- All 128-bit buses use [0:127] ordering: byte 0 = bits [0:7], column-major as in FIPS-197.

Parameters:
- NR, 10, number of rounds. Legal range 2..10; final round is round NR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key present.
- in_ready  out  1  block can accept a new plaintext/key.
- pt  in  128  plaintext, sampled on acceptance.
- key  in  128  cipher key, sampled on acceptance.
- rnd_state  out  128  current state register, feeds the external round datapath.
- rk_cur  out  128  current round-key register (round key r-1), feeds key expansion.
- rcon  out  8  Rcon byte for the round being computed.
- final_round  out  1  high when round == NR; external datapath bypasses MixColumns.
- rk_next  in  128  round key r from external key expansion (combinational from rk_cur, rcon).
- rnd_result  in  128  external round output (combinational from rnd_state, rk_next, final_round).
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- ct  out  128  ciphertext; equals state register.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset (async, rst=1):
  - FSM = IDLE; state_reg = 0; rk_reg = 0; round = 0.
  - Outputs: in_ready=0 while rst is high, 1 in IDLE after release; out_valid=0; busy=0; final_round=0; rcon=8'h00.
  - Reset mid-operation aborts the block; no partial output is presented.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready: state_reg <= pt ^ key (initial AddRoundKey); rk_reg <= key; round <= 1; go to ROUND.
- ROUND:
  - in_ready=0; busy=1.
  - rcon = Rcon(round), with Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36; rcon=00 outside ROUND.
  - final_round = (round==NR).
  - Each edge: state_reg <= rnd_result; rk_reg <= rk_next.
  - If round==NR: go to DONE, round <= 0. Otherwise round <= round+1.
  - round is a 4-bit counter and never exceeds NR.
- DONE:
  - out_valid=1; ct=state_reg stable; busy=1; in_ready=0.
  - On out_valid&out_ready: go to IDLE. in_ready rises the following cycle; no same-cycle reload.
  - out_ready low holds ct and out_valid indefinitely.
- Latency: acceptance edge E0; round r is written at edge Er. out_valid is high from E_NR until the handshake (10 cycles for NR=10).
- Throughput: one block per NR+2 cycles minimum.
- in_valid while busy is ignored: no sampling, no state change. pt/key may change freely after acceptance.
- out_ready while not out_valid has no effect.
- rnd_state, rk_cur always reflect the registers, including in IDLE/DONE (don't-care for consumers outside ROUND).
- No combinational path from any input to in_ready, out_valid or busy.

Test Plan:
- FIPS-197 App. B, bench models round/key expansion: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after acceptance.
- Rcon/final_round trace over the same run -> rcon sequence 01,02,04,08,10,20,40,80,1b,36 on cycles 1..10; final_round high only on cycle 10; rnd_state on cycle 1 = 193de3bea0f4e22b9ac68d2ae9f84808.
- Backpressure: hold out_ready=0 for 20 cycles after done -> ct and out_valid stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Ignored input: pulse in_valid with a different pt/key on round 5 -> ct unchanged (3925841d…0b32).
- Async reset mid-round: assert rst between edges in round 4 -> out_valid=0, in_ready=0, busy=0 immediately; after release, a new FIPS vector completes correctly.
- Back-to-back: keep in_valid=1 with two blocks, out_ready=1 -> second acceptance exactly 12 cycles after the first; both ciphertexts correct.
